// File: rtl/sbuf_pkg.sv
// Shared state encoding and parameter defaults for the sbuf run sequencer.
// Latency/backpressure: none, declarations only.
package sbuf_pkg;

    localparam int SBUF_LEN_W    = 8;
    localparam int SBUF_ADR_W    = 9;
    localparam int SBUF_WDOG_MAX = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sbuf_state_e;

endpackage

// File: rtl/sbuf_seq_if.sv
// Command, array-write and sbuf read-port signals of the run sequencer.
// Latency/backpressure: none, wiring only; slave is the sequencer side.
interface sbuf_seq_if
    import sbuf_pkg::*;
#(
    parameter int LEN_W = SBUF_LEN_W,
    parameter int ADR_W = SBUF_ADR_W
);
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_go;
    logic             cmd_abort;
    logic             cmd_busy;
    logic             cmd_done;
    logic             cmd_aborted;
    logic             arr_valid;
    logic             start;
    logic [LEN_W-1:0] run_cntr;
    logic             sw;
    logic             finish;
    logic             cpu_rreq;
    logic             drn_rreq;
    logic [ADR_W-1:0] cpu_radr;
    logic [ADR_W-1:0] drn_radr;
    logic             cpu_rgnt;
    logic             drn_rgnt;
    logic             cpu_rvalid;
    logic             drn_rvalid;
    logic [ADR_W-1:0] sbus_radr;

    modport slave (
        input  cmd_len, cmd_go, cmd_abort, arr_valid, finish,
        input  cpu_rreq, drn_rreq, cpu_radr, drn_radr,
        output cmd_busy, cmd_done, cmd_aborted, start, run_cntr, sw,
        output cpu_rgnt, drn_rgnt, cpu_rvalid, drn_rvalid, sbus_radr
    );

    modport master (
        output cmd_len, cmd_go, cmd_abort, arr_valid, finish,
        output cpu_rreq, drn_rreq, cpu_radr, drn_radr,
        input  cmd_busy, cmd_done, cmd_aborted, start, run_cntr, sw,
        input  cpu_rgnt, drn_rgnt, cpu_rvalid, drn_rvalid, sbus_radr
    );

endinterface

// File: rtl/sbuf_rd_arb.sv
// Two-requester round-robin arbiter for the single sbuf read port (CPU vs drain).
// Latency: grant/address same cycle, rvalid one cycle later; loser simply retries.
module sbuf_rd_arb
    import sbuf_pkg::*;
#(
    parameter int ADR_W = SBUF_ADR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_rreq,
    input  logic [ADR_W-1:0] cpu_radr,
    input  logic             drn_rreq,
    input  logic [ADR_W-1:0] drn_radr,
    output logic             cpu_rgnt,
    output logic             drn_rgnt,
    output logic             cpu_rvalid,
    output logic             drn_rvalid,
    output logic [ADR_W-1:0] sbus_radr
);

    logic last_drn_q, last_drn_d;
    logic cpu_rvalid_q, cpu_rvalid_d;
    logic drn_rvalid_q, drn_rvalid_d;

    always_comb begin
        cpu_rgnt     = cpu_rreq & (~drn_rreq | last_drn_q);
        drn_rgnt     = drn_rreq & ~cpu_rgnt;
        sbus_radr    = '0;
        last_drn_d   = last_drn_q;
        cpu_rvalid_d = cpu_rgnt;
        drn_rvalid_d = drn_rgnt;
        if (cpu_rgnt) begin
            sbus_radr  = cpu_radr;
            last_drn_d = 1'b0;
        end else if (drn_rgnt) begin
            sbus_radr  = drn_radr;
            last_drn_d = 1'b1;
        end
    end

    // Pointer starts at drain so the CPU takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_drn_q   <= 1'b1;
            cpu_rvalid_q <= 1'b0;
            drn_rvalid_q <= 1'b0;
        end else begin
            last_drn_q   <= last_drn_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            drn_rvalid_q <= drn_rvalid_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign drn_rvalid = drn_rvalid_q;

endmodule

// File: rtl/sbuf_seq.sv
// sbuf run sequencer (start/run_cntr/sw until finish) plus read-port arbiter; SBUF_SEQ_WDOG_EN adds an idle watchdog.
// Latency: start at go+1, sw combinational on arr_valid, done at finish+1; no backpressure, abort wins.
module sbuf_seq
    import sbuf_pkg::*;
#(
    parameter int LEN_W = SBUF_LEN_W,
    parameter int ADR_W = SBUF_ADR_W
`ifdef SBUF_SEQ_WDOG_EN
    , parameter int WDOG_MAX = SBUF_WDOG_MAX
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    sbuf_seq_if.slave  bus
`ifdef SBUF_SEQ_WDOG_EN
    , output logic     wdog_err
`endif
);

    sbuf_state_e      state_q, state_d;
    logic [LEN_W-1:0] run_cntr_q, run_cntr_d;
    logic             aborted_q, aborted_d;
    logic             abort_any;
    logic             sw_c;

`ifdef SBUF_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_MAX + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wdog_err_q, wdog_err_d;
    logic            wd_hit;
    logic            go_acc;

    assign go_acc = (state_q == ST_IDLE) & bus.cmd_go;

    // Fires on the WDOG_MAX-th consecutive idle RUN cycle, counting the current one.
    always_comb begin
        wd_cnt_d   = '0;
        wd_hit     = 1'b0;
        wdog_err_d = wdog_err_q;
        if (state_q == ST_RUN && !bus.arr_valid) begin
            wd_hit   = (wd_cnt_q == WD_W'(WDOG_MAX - 1));
            wd_cnt_d = wd_hit ? '0 : wd_cnt_q + 1'b1;
        end
        if (go_acc) begin
            wdog_err_d = 1'b0;
        end else if (wd_hit) begin
            wdog_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign abort_any = bus.cmd_abort | wd_hit;
    assign wdog_err  = wdog_err_q;
`else
    assign abort_any = bus.cmd_abort;
`endif

    always_comb begin
        state_d    = state_q;
        run_cntr_d = run_cntr_q;
        aborted_d  = 1'b0;
        sw_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_go) begin
                    run_cntr_d = bus.cmd_len;
                    state_d    = ST_START;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                sw_c = bus.arr_valid & ~abort_any;
                if (sw_c && bus.finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // The sbuf counter is left stale on abort; the next start reloads it.
        if (state_q != ST_IDLE && abort_any) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            run_cntr_q <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cntr_q <= run_cntr_d;
            aborted_q  <= aborted_d;
        end
    end

    assign bus.cmd_busy    = (state_q != ST_IDLE);
    assign bus.start       = (state_q == ST_START);
    assign bus.cmd_done    = (state_q == ST_DONE);
    assign bus.cmd_aborted = aborted_q;
    assign bus.run_cntr    = run_cntr_q;
    assign bus.sw          = sw_c;

    sbuf_rd_arb #(.ADR_W(ADR_W)) u_rd_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_rreq   (bus.cpu_rreq),
        .cpu_radr   (bus.cpu_radr),
        .drn_rreq   (bus.drn_rreq),
        .drn_radr   (bus.drn_radr),
        .cpu_rgnt   (bus.cpu_rgnt),
        .drn_rgnt   (bus.drn_rgnt),
        .cpu_rvalid (bus.cpu_rvalid),
        .drn_rvalid (bus.drn_rvalid),
        .sbus_radr  (bus.sbus_radr)
    );

endmodule

// File: tb/tb_sbuf_seq.sv
// Bench for sbuf_seq: per-cycle vector table for the sequencer, scoreboard queue for read grants.
// An sbuf counter model closes the start/sw/finish loop.
module tb_sbuf_seq;
    import sbuf_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sbuf_seq_if ifc ();

`ifdef SBUF_SEQ_WDOG_EN
    logic wdog_err;
    sbuf_seq #(.WDOG_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc), .wdog_err(wdog_err));
`else
    sbuf_seq dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
`endif

    // sbuf model: start loads N, each sw counts down, finish marks the (N+1)-th write.
    logic [7:0] sb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       sb_cnt <= 8'd0;
        else if (ifc.start)               sb_cnt <= ifc.run_cntr;
        else if (ifc.sw && sb_cnt != 8'd0) sb_cnt <= sb_cnt - 8'd1;
    end
    assign ifc.finish = ifc.sw && (sb_cnt == 8'd0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // exp = {busy, start, sw, done, aborted}
    typedef struct {
        logic       go;
        logic [7:0] len;
        logic       abort;
        logic       av;
        logic [4:0] exp;
        logic [7:0] cntr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic go, input logic [7:0] len, input logic abort,
                       input logic av, input logic [4:0] exp, input logic [7:0] cntr);
        vec_t v;
        v.go = go; v.len = len; v.abort = abort; v.av = av; v.exp = exp; v.cntr = cntr;
        vecs.push_back(v);
    endtask

    function automatic logic [4:0] seq_out();
        return {ifc.cmd_busy, ifc.start, ifc.sw, ifc.cmd_done, ifc.cmd_aborted};
    endfunction

    // Read-arbiter scoreboard: expected {cpu_rvalid, drn_rvalid} for the following cycle.
    logic [1:0] rv_q[$];
    bit         m_last_drn = 1'b1;

    task automatic arb_cycle(input logic cr, input logic dr,
                             input logic [8:0] ca, input logic [8:0] da);
        logic       eg_c, eg_d;
        logic [8:0] ea;
        logic [1:0] ev;
        @(posedge clk); #1;
        ifc.cpu_rreq = cr; ifc.drn_rreq = dr; ifc.cpu_radr = ca; ifc.drn_radr = da;
        eg_c = cr && (!dr || m_last_drn);
        eg_d = dr && !eg_c;
        ea   = eg_c ? ca : (eg_d ? da : 9'h000);
        if (eg_c)      m_last_drn = 1'b0;
        else if (eg_d) m_last_drn = 1'b1;
        @(negedge clk);
        chk("grant", 32'({ifc.cpu_rgnt, ifc.drn_rgnt}), 32'({eg_c, eg_d}));
        chk("sbus_radr", 32'(ifc.sbus_radr), 32'(ea));
        checks++;
        if (rv_q.size() == 0) begin
            errors++;
            $display("FAIL rvalid: scoreboard empty, got %b", {ifc.cpu_rvalid, ifc.drn_rvalid});
        end else begin
            ev = rv_q.pop_front();
            if ({ifc.cpu_rvalid, ifc.drn_rvalid} !== ev) begin
                errors++;
                $display("FAIL rvalid: got %b expected %b", {ifc.cpu_rvalid, ifc.drn_rvalid}, ev);
            end
        end
        rv_q.push_back({eg_c, eg_d});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int  n_sw;
        bit  got;
        int  at;

        ifc.cmd_len = '0; ifc.cmd_go = 1'b0; ifc.cmd_abort = 1'b0; ifc.arr_valid = 1'b0;
        ifc.cpu_rreq = 1'b0; ifc.drn_rreq = 1'b0; ifc.cpu_radr = '0; ifc.drn_radr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_seq", 32'(seq_out()), 32'd0);
        chk("reset_cntr", 32'(ifc.run_cntr), 32'd0);
        chk("reset_rd", 32'({ifc.cpu_rgnt, ifc.drn_rgnt, ifc.cpu_rvalid, ifc.drn_rvalid}), 32'd0);
`ifdef SBUF_SEQ_WDOG_EN
        chk("reset_wdog", 32'(wdog_err), 32'd0);
`endif
        rst_n = 1'b1;

        // len 3, continuous valid: start@1, sw@2..5, done@6, idle@7
        add(1, 3, 0, 1, 5'b00000, 0);
        add(0, 0, 0, 1, 5'b11000, 3);
        add(0, 0, 0, 1, 5'b10100, 3);
        add(0, 0, 0, 1, 5'b10100, 3);
        add(0, 0, 0, 1, 5'b10100, 3);
        add(0, 0, 0, 1, 5'b10100, 3);
        add(0, 0, 0, 1, 5'b10010, 3);
        add(0, 0, 0, 0, 5'b00000, 3);
        // len 2, valid pattern 1,0,0,1,1
        add(1, 2, 0, 0, 5'b00000, 3);
        add(0, 0, 0, 0, 5'b11000, 2);
        add(0, 0, 0, 1, 5'b10100, 2);
        add(0, 0, 0, 0, 5'b10000, 2);
        add(0, 0, 0, 0, 5'b10000, 2);
        add(0, 0, 0, 1, 5'b10100, 2);
        add(0, 0, 0, 1, 5'b10100, 2);
        add(0, 0, 0, 0, 5'b10010, 2);
        add(0, 0, 0, 0, 5'b00000, 2);
        // abort in RUN after one write, then a len-0 run
        add(1, 5, 0, 1, 5'b00000, 2);
        add(0, 0, 0, 1, 5'b11000, 5);
        add(0, 0, 0, 1, 5'b10100, 5);
        add(0, 0, 1, 1, 5'b10000, 5);
        add(0, 0, 0, 1, 5'b00001, 5);
        add(1, 0, 0, 1, 5'b00000, 5);
        add(0, 0, 0, 1, 5'b11000, 0);
        add(0, 0, 0, 1, 5'b10100, 0);
        add(0, 0, 0, 1, 5'b10010, 0);
        add(0, 0, 0, 0, 5'b00000, 0);
        // abort in IDLE does nothing
        add(0, 0, 1, 1, 5'b00000, 0);
        add(0, 0, 0, 0, 5'b00000, 0);
        // go while busy and with done are ignored; accepted once busy is low
        add(1, 1, 0, 1, 5'b00000, 0);
        add(1, 7, 0, 1, 5'b11000, 1);
        add(1, 7, 0, 1, 5'b10100, 1);
        add(0, 0, 0, 1, 5'b10100, 1);
        add(1, 7, 0, 0, 5'b10010, 1);
        add(1, 0, 0, 0, 5'b00000, 1);
        add(0, 0, 0, 1, 5'b11000, 0);
        add(0, 0, 0, 1, 5'b10100, 0);
        add(0, 0, 0, 0, 5'b10010, 0);
        add(0, 0, 0, 0, 5'b00000, 0);
        // abort during START
        add(1, 2, 0, 1, 5'b00000, 0);
        add(0, 0, 1, 1, 5'b11000, 2);
        add(0, 0, 0, 1, 5'b00001, 2);
        add(0, 0, 0, 0, 5'b00000, 2);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            ifc.cmd_go = vecs[i].go; ifc.cmd_len = vecs[i].len;
            ifc.cmd_abort = vecs[i].abort; ifc.arr_valid = vecs[i].av;
            @(negedge clk);
            chk($sformatf("vec%0d_seq", i), 32'(seq_out()), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_cntr", i), 32'(ifc.run_cntr), 32'(vecs[i].cntr));
        end

        // N=255 gives 256 writes
        @(posedge clk); #1;
        ifc.cmd_go = 1'b1; ifc.cmd_len = 8'd255; ifc.arr_valid = 1'b1; ifc.cmd_abort = 1'b0;
        @(posedge clk); #1;
        ifc.cmd_go = 1'b0;
        n_sw = 0; got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ifc.sw) n_sw++;
            if (ifc.cmd_done) begin got = 1'b1; break; end
        end
        chk("n255_done_seen", 32'(got), 32'd1);
        chk("n255_writes", 32'(n_sw), 32'd256);
        @(posedge clk); #1;
        ifc.arr_valid = 1'b0;
        @(negedge clk);
        chk("n255_idle", 32'(seq_out()), 32'd0);

        // Read arbiter, both requesting then single requesters and idle
        rv_q.push_back(2'b00);
        for (int i = 0; i < 6; i++) arb_cycle(1'b1, 1'b1, 9'h010, 9'h105);
        for (int i = 0; i < 2; i++) arb_cycle(1'b1, 1'b0, 9'($urandom_range(511)), 9'h1AA);
        for (int i = 0; i < 2; i++) arb_cycle(1'b0, 1'b1, 9'h0AA, 9'($urandom_range(511)));
        arb_cycle(1'b0, 1'b0, 9'h123, 9'h045);
        for (int i = 0; i < 3; i++) arb_cycle(1'b1, 1'b1, 9'($urandom_range(511)), 9'($urandom_range(511)));
        arb_cycle(1'b1, 1'b0, 9'h011, 9'h000);
        arb_cycle(1'b1, 1'b1, 9'h012, 9'h1FF);
        arb_cycle(1'b0, 1'b0, 9'h000, 9'h000);

`ifdef SBUF_SEQ_WDOG_EN
        // Watchdog: 4 idle RUN cycles abort the run and set wdog_err
        @(posedge clk); #1;
        ifc.cmd_go = 1'b1; ifc.cmd_len = 8'd3; ifc.arr_valid = 1'b0;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                @(posedge clk); #1;
                ifc.cmd_go = 1'b0;
                @(negedge clk);
                i++;
            end
            if (ifc.cmd_aborted) begin at = i; break; end
        end
        chk("wdog_abort_cycle", 32'(at), 32'd6);
        chk("wdog_err_set", 32'(wdog_err), 32'd1);
        chk("wdog_idle", 32'(ifc.cmd_busy), 32'd0);
        @(posedge clk); #1;
        ifc.cmd_go = 1'b1; ifc.cmd_len = 8'd0; ifc.arr_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_go = 1'b0;
        @(negedge clk);
        chk("wdog_err_clear", 32'(wdog_err), 32'd0);
        repeat (3) @(posedge clk);
        #1 ifc.arr_valid = 1'b0;
`else
        at = 0;
`endif

        // Reset mid-run drops the run silently
        @(posedge clk); #1;
        ifc.cmd_go = 1'b1; ifc.cmd_len = 8'd5; ifc.arr_valid = 1'b1;
        @(posedge clk); #1;
        ifc.cmd_go = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_seq", 32'(seq_out()), 32'd0);
        chk("midrst_cntr", 32'(ifc.run_cntr), 32'd0);
`ifdef SBUF_SEQ_WDOG_EN
        chk("midrst_wdog", 32'(wdog_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d", i), 32'(seq_out()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbuf_seq.md
# sbuf_seq

Run sequencer and read-port arbiter for the systolic output buffer (sbuf). It accepts a run command from the CPU register block and issues the `start` pulse and `run_cntr` length. It then generates one `sw` write strobe per valid array output until sbuf signals `finish`, and shares the single sbuf read address port between the CPU and the drain engine.

## Interface
Parameters:
- LEN_W, 8: run-length width; matches `run_cntr`.
- ADR_W, 9: sbuf read address width; bit 8 selects the saturation buffer.
- WDOG_MAX, 255: idle-cycle limit for the watchdog (only with SBUF_SEQ_WDOG_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cmd_len  in  LEN_W  run length N; the run writes N+1 entries
- cmd_go  in  1  one-cycle run request
- cmd_abort  in  1  one-cycle abort request
- cmd_busy  out  1  sequencer not IDLE
- cmd_done  out  1  one-cycle pulse: run completed
- cmd_aborted  out  1  one-cycle pulse: run aborted (by command or watchdog)
- arr_valid  in  1  systolic array output word valid this cycle
- start  out  1  to sbuf: load counter, clear write addresses
- run_cntr  out  LEN_W  to sbuf: latched N
- sw  out  1  to sbuf: write strobe
- finish  in  1  from sbuf: last write (combinational on `sw`)
- cpu_rreq / drn_rreq  in  1  read requests
- cpu_radr / drn_radr  in  ADR_W  read addresses
- cpu_rgnt / drn_rgnt  out  1  grant, same cycle as request
- cpu_rvalid / drn_rvalid  out  1  `sbus_rdata` valid for that requester
- sbus_radr  out  ADR_W  to sbuf read port

## Operation
- States are IDLE, START, RUN and DONE.
- **IDLE:**
  - `cmd_go` latches `cmd_len` into `run_cntr` and moves to START.
  - `cmd_go` in any other state is ignored (no queueing).
- **START:**
  - `start` is 1 for exactly one cycle.
  - Next state is RUN.
- **RUN:**
  - `sw` = `arr_valid`, combinational.
  - `sw & finish` moves to DONE.
  - For N, exactly N+1 `sw` pulses occur (N=0 gives 1 write; N=255 gives 256 writes).
- **DONE:** `cmd_done` is 1 for one cycle, then the state returns to IDLE.
- **Abort:**
  - `cmd_abort` has the highest priority in START, RUN and DONE: it goes to IDLE next cycle and pulses `cmd_aborted`.
  - While `cmd_abort` is high, `sw` is forced to 0.
  - The sbuf counter is left stale; the next `start` reloads it.
  - `cmd_abort` in IDLE has no effect.
- `sw` is 0 outside RUN; `start` is 0 outside START.
- **Read arbiter:**
  - Round-robin between CPU and drain.
  - The last-grant pointer resets to drain, so the CPU wins the first tie.
  - A single requester always wins.
  - `sbus_radr` is the granted address, or 0 when there is no request.
  - Reads are permitted in every state, including RUN; sbuf is 1R1W.
- **Reset values:**
  - IDLE; `run_cntr`=0; all strobes, grants and valids 0.
  - Reset mid-run drops the run silently; no `cmd_done` or `cmd_aborted` is produced.

## Timing
- `cmd_go` at cycle T:
  - `cmd_busy` and `start` are 1 at T+1.
  - RUN begins at T+2; the earliest `sw` is at T+2.
- The final `sw` at cycle F coincides with `finish`:
  - `cmd_done` pulses at F+1.
  - `cmd_busy` falls at F+2.
  - A new `cmd_go` is accepted at F+2.
- Minimum run (N=0, `arr_valid` held high): `cmd_go`@0, `start`@1, `sw`@2, `cmd_done`@3.
- Grant is combinational at cycle R; `*_rvalid` is registered and asserts at R+1, aligned with `sbus_rdata`.
- Back-to-back requests from both requesters alternate every cycle.

## Configuration
- SBUF_SEQ_WDOG_EN defined:
  - A counter in RUN counts consecutive cycles with `arr_valid`=0 and clears on `arr_valid`.
  - When it reaches WDOG_MAX, the block behaves as `cmd_abort` at that cycle.
  - A sticky `wdog_err` output (1 bit, cleared by the next accepted `cmd_go`) is added.
- Undefined: no counter, no `wdog_err` port, and RUN waits indefinitely.

## Structure
- Shared package `sbuf_pkg` holds:
  - the state enum (IDLE/START/RUN/DONE);
  - LEN_W/ADR_W defaults;
  - the WDOG_MAX default.
- Sub-module `sbuf_rd_arb` contains the two-requester round-robin arbiter, the address mux and the registered rvalid.
- The top level holds the FSM, the `run_cntr` latch and the optional watchdog.

## Test plan
- `cmd_len`=3, `arr_valid`=1 continuously, sbuf model attached → `start`@1, `sw` at cycles 2–5 (4 pulses), `cmd_done`@6, `cmd_busy` low @7.
- `cmd_len`=2, `arr_valid` pattern 1,0,0,1,1 → `sw` only on valid cycles; 3 writes total; `cmd_done` one cycle after the third.
- `cmd_abort` during RUN after 1 write → `sw` 0 from that cycle, `cmd_aborted`@+1, IDLE; a following `cmd_go` with len 0 completes normally.
- `cmd_go` asserted while busy, and again simultaneously with `cmd_done` → both ignored; accepted at the cycle after `cmd_busy` falls.
- CPU and drain both requesting every cycle, `cpu_radr`=0x010, `drn_radr`=0x105 → grants CPU, drain, CPU…; `sbus_radr` alternates; `rvalid` one cycle later per winner.
- With SBUF_SEQ_WDOG_EN and WDOG_MAX=4: RUN with `arr_valid`=0 → `cmd_aborted` and `wdog_err`=1 after 4 idle cycles; `rst_n` low mid-run → all outputs 0, IDLE.
